// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the ex_muldiv RV32M unit: op codes, FSM states, divide constants.
package ex_muldiv_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int ALU_OP_WIDTH = 5;

    // M-extension ops are contiguous; anything outside ALU_MUL..ALU_REMU is not a request.
    localparam logic [ALU_OP_WIDTH-1:0] ALU_MUL    = 5'd16;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_MULH   = 5'd17;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_MULHSU = 5'd18;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_MULHU  = 5'd19;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_DIV    = 5'd20;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_DIVU   = 5'd21;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_REM    = 5'd22;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_REMU   = 5'd23;

    localparam logic [DATA_WIDTH-1:0] DIV_ZERO_Q = '1;
    localparam logic [DATA_WIDTH-1:0] DIV_OVF_Q  = 32'h8000_0000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } md_state_t;

    function automatic logic op_valid(input logic [ALU_OP_WIDTH-1:0] op);
        return (op >= ALU_MUL) && (op <= ALU_REMU);
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Request/response bundle between issue logic and the ex_muldiv unit.
interface ex_muldiv_if import ex_muldiv_pkg::*; ();
    // Handshake: a request is a valid m_AluOp; it is taken in a cycle where md_busy=0 and
    // md_flush=0, otherwise the master holds it unchanged. md_done pulses one cycle with the result.
    logic [ALU_OP_WIDTH-1:0] m_AluOp;
    logic [DATA_WIDTH-1:0]   m_s1;
    logic [DATA_WIDTH-1:0]   m_s2;
    logic [1:0]              m_prio;
    logic                    md_flush;
    logic                    md_busy;
    logic                    md_done;
    logic [DATA_WIDTH-1:0]   md_result;
    logic [1:0]              md_slot;
    logic [2:0]              md_state;

    modport master (
        output m_AluOp, m_s1, m_s2, m_prio, md_flush,
        input  md_busy, md_done, md_result, md_slot, md_state
    );

    modport slave (
        input  m_AluOp, m_s1, m_s2, m_prio, md_flush,
        output md_busy, md_done, md_result, md_slot, md_state
    );
endinterface

// File: rtl/ex_muldiv_md_div_core.sv
// Radix-2 restoring divider on unsigned magnitudes; one quotient bit per cycle.
module md_div_core import ex_muldiv_pkg::*; #(
    parameter int DIV_CNT_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_flush,
    input  logic [DATA_WIDTH-1:0] i_dividend,
    input  logic [DATA_WIDTH-1:0] i_divisor,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_quo,
    output logic [DATA_WIDTH-1:0] o_rem
);
    logic [DIV_CNT_W-1:0]  r_cnt;
    logic                  r_run;
    logic [DATA_WIDTH-1:0] r_quo;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] r_dvs;
    logic [DATA_WIDTH:0]   w_shift;
    logic [DATA_WIDTH:0]   w_diff;

    // Partial remainder needs one extra bit after the shift; a set MSB in the difference means restore.
    assign w_shift = {r_rem, r_quo[DATA_WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};
    assign o_done  = r_run && (r_cnt == '0);
    assign o_quo   = r_quo;
    assign o_rem   = r_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_run <= 1'b0;
            r_quo <= '0;
            r_rem <= '0;
            r_dvs <= '0;
        end else if (i_flush) begin
            r_run <= 1'b0;
        end else if (i_start) begin
            r_cnt <= DIV_CNT_W'(DATA_WIDTH - 1);
            r_run <= 1'b1;
            r_quo <= i_dividend;
            r_rem <= '0;
            r_dvs <= i_divisor;
        end else if (r_run) begin
            if (!w_diff[DATA_WIDTH]) begin
                r_rem <= w_diff[DATA_WIDTH-1:0];
                r_quo <= {r_quo[DATA_WIDTH-2:0], 1'b1};
            end else begin
                r_rem <= w_shift[DATA_WIDTH-1:0];
                r_quo <= {r_quo[DATA_WIDTH-2:0], 1'b0};
            end
            if (r_cnt == '0) begin
                r_run <= 1'b0;
            end else begin
                r_cnt <= r_cnt - DIV_CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: FSM, two-cycle multiplier and divide sign fix-up.
// Optional MULDIV_EARLY_OUT_EN: divides with |dividend| < |divisor| complete in one cycle.
module ex_muldiv import ex_muldiv_pkg::*; #(
    parameter int DIV_CNT_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    ex_muldiv_if.slave  bus
);
    md_state_t               r_state;
    logic [ALU_OP_WIDTH-1:0] r_op;
    logic [DATA_WIDTH-1:0]   r_a;
    logic [DATA_WIDTH-1:0]   r_b;
    logic [1:0]              r_tag;
    logic                    r_neg_q;
    logic                    r_neg_r;
    logic [DATA_WIDTH-1:0]   r_result;
    logic [1:0]              r_slot;

    logic                    w_accept, w_is_div, w_is_rem, w_signed_div;
    logic                    w_s1_neg, w_s2_neg, w_div_zero, w_div_ovf, w_early, w_start;
    logic [DATA_WIDTH-1:0]   w_mag1, w_mag2;
    logic                    w_a_sgn, w_b_sgn;
    logic [63:0]             w_a64, w_b64, w_prod;
    logic [DATA_WIDTH-1:0]   w_mul_res, w_div_res, w_quo, w_rem;
    logic                    w_div_done;

    assign w_accept     = (r_state == ST_IDLE) && op_valid(bus.m_AluOp) && !bus.md_flush;
    assign w_is_div     = bus.m_AluOp >= ALU_DIV;
    assign w_is_rem     = (bus.m_AluOp == ALU_REM) || (bus.m_AluOp == ALU_REMU);
    assign w_signed_div = (bus.m_AluOp == ALU_DIV) || (bus.m_AluOp == ALU_REM);
    assign w_s1_neg     = w_signed_div && bus.m_s1[DATA_WIDTH-1];
    assign w_s2_neg     = w_signed_div && bus.m_s2[DATA_WIDTH-1];
    assign w_mag1       = w_s1_neg ? (DATA_WIDTH'(0) - bus.m_s1) : bus.m_s1;
    assign w_mag2       = w_s2_neg ? (DATA_WIDTH'(0) - bus.m_s2) : bus.m_s2;
    assign w_div_zero   = (bus.m_s2 == '0);
    assign w_div_ovf    = w_signed_div && (bus.m_s1 == DIV_OVF_Q) && (bus.m_s2 == '1);
`ifdef MULDIV_EARLY_OUT_EN
    assign w_early      = (w_mag1 < w_mag2);
`else
    assign w_early      = 1'b0;
`endif
    assign w_start      = w_accept && w_is_div && !w_div_zero && !w_div_ovf && !w_early;

    // Sign-extend to 64 bits; the low 64 bits of the wrapped product equal the true product.
    assign w_a_sgn   = (r_op == ALU_MULH) || (r_op == ALU_MULHSU);
    assign w_b_sgn   = (r_op == ALU_MULH);
    assign w_a64     = {{32{w_a_sgn & r_a[DATA_WIDTH-1]}}, r_a};
    assign w_b64     = {{32{w_b_sgn & r_b[DATA_WIDTH-1]}}, r_b};
    assign w_prod    = w_a64 * w_b64;
    assign w_mul_res = (r_op == ALU_MUL) ? w_prod[31:0] : w_prod[63:32];

    assign w_div_res = ((r_op == ALU_REM) || (r_op == ALU_REMU))
                     ? (r_neg_r ? (DATA_WIDTH'(0) - w_rem) : w_rem)
                     : (r_neg_q ? (DATA_WIDTH'(0) - w_quo) : w_quo);

    md_div_core #(.DIV_CNT_W(DIV_CNT_W)) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_start),
        .i_flush    (bus.md_flush),
        .i_dividend (w_mag1),
        .i_divisor  (w_mag2),
        .o_done     (w_div_done),
        .o_quo      (w_quo),
        .o_rem      (w_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_tag    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
            r_slot   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_op    <= bus.m_AluOp;
                    r_a     <= bus.m_s1;
                    r_b     <= bus.m_s2;
                    r_tag   <= bus.m_prio;
                    r_neg_q <= w_s1_neg ^ w_s2_neg;
                    r_neg_r <= w_s1_neg;
                    if (!w_is_div) begin
                        r_state <= ST_MUL;
                    end else if (w_div_zero || w_div_ovf || w_early) begin
                        r_state <= ST_DONE;
                        r_slot  <= bus.m_prio;
                        if (w_div_zero)     r_result <= w_is_rem ? bus.m_s1 : DIV_ZERO_Q;
                        else if (w_div_ovf) r_result <= w_is_rem ? '0 : DIV_OVF_Q;
                        else                r_result <= w_is_rem ? bus.m_s1 : '0;
                    end else begin
                        r_state <= ST_DIV;
                    end
                end
                ST_MUL: if (bus.md_flush) r_state <= ST_IDLE;
                        else begin
                            r_state  <= ST_DONE;
                            r_result <= w_mul_res;
                            r_slot   <= r_tag;
                        end
                ST_DIV: if (bus.md_flush)   r_state <= ST_IDLE;
                        else if (w_div_done) r_state <= ST_FIX;
                ST_FIX: if (bus.md_flush) r_state <= ST_IDLE;
                        else begin
                            r_state  <= ST_DONE;
                            r_result <= w_div_res;
                            r_slot   <= r_tag;
                        end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.md_busy   = (r_state != ST_IDLE);
    assign bus.md_done   = (r_state == ST_DONE);
    assign bus.md_result = r_result;
    assign bus.md_slot   = r_slot;
    assign bus.md_state  = r_state;
endmodule

// File: tb/tb_ex_muldiv.sv
// Randomized and directed checks of ex_muldiv against an arithmetic reference model.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [31:0] exp_q[$];

    ex_muldiv_if bus ();
    ex_muldiv dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: RISC-V M semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        int ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        ia = a;
        ib = b;
        case (op)
            ALU_MUL:    begin p = 64'(ua * ub); return p[31:0];  end
            ALU_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
            ALU_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
            ALU_MULHU:  begin p = 64'(ua * ub); return p[63:32]; end
            ALU_DIV:    if (b == 0) return 32'hFFFF_FFFF;
                        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                        else return 32'(ia / ib);
            ALU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_REM:    if (b == 0) return a;
                        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                        else return 32'(ia % ib);
            default:    return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic sgn;
        longint ma, mb;
        if (op < ALU_DIV) return 2;
        sgn = (op == ALU_DIV) || (op == ALU_REM);
        if (b == 0) return 1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        ma = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        mb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
`ifdef MULDIV_EARLY_OUT_EN
        if (ma < mb) return 1;
`endif
        return 34;
    endfunction

    // Presents a request from an idle cycle, drops it after one cycle, waits for md_done.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [1:0] prio,
                          output int lat, output logic [31:0] res, output logic [1:0] slot);
        logic got;
        bus.m_AluOp = op;
        bus.m_s1    = a;
        bus.m_s2    = b;
        bus.m_prio  = prio;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            tick();
            lat++;
            if (lat == 1) bus.m_AluOp = 5'd0;
            if (bus.md_done) got = 1'b1;
        end
        res  = bus.md_result;
        slot = bus.md_slot;
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout op=%0d: no md_done within %0d cycles", op, lat);
        end
        tick();
    endtask

    task automatic test_reset();
        n_tests++; if (bus.md_busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.md_busy); end
        n_tests++; if (bus.md_done !== 1'b0)    begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.md_done); end
        n_tests++; if (bus.md_result !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", bus.md_result); end
        n_tests++; if (bus.md_slot !== 2'd0)    begin n_fail++; $display("FAIL reset_slot got=%0d exp=0", bus.md_slot); end
        n_tests++; if (bus.md_state !== 3'd0)   begin n_fail++; $display("FAIL reset_state got=%0d exp=0", bus.md_state); end
    endtask

    task automatic test_mul();
        int lat; logic [31:0] res; logic [1:0] slot;
        run_op(ALU_MUL, 32'd7, 32'hFFFF_FFFD, 2'd2, lat, res, slot);
        n_tests++; if (lat !== 2)             begin n_fail++; $display("FAIL mul_latency got=%0d exp=2", lat); end
        n_tests++; if (res !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_result got=%h exp=ffffffeb", res); end
        n_tests++; if (slot !== 2'd2)         begin n_fail++; $display("FAIL mul_slot got=%0d exp=2", slot); end
        run_op(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd1, lat, res, slot);
        n_tests++; if (res !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mulhu got=%h exp=fffffffe", res); end
        run_op(ALU_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd1, lat, res, slot);
        n_tests++; if (res !== 32'h0)         begin n_fail++; $display("FAIL mulh got=%h exp=0", res); end
        run_op(ALU_MULHSU, 32'hFFFF_FFFF, 32'd2, 2'd3, lat, res, slot);
        n_tests++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mulhsu got=%h exp=ffffffff", res); end
        n_tests++; if (slot !== 2'd3)         begin n_fail++; $display("FAIL mulhsu_slot got=%0d exp=3", slot); end
    endtask

    task automatic test_div_special();
        int lat; logic [31:0] res; logic [1:0] slot;
        logic [4:0]  ops[4] = '{ALU_DIVU, ALU_REMU, ALU_DIV, ALU_REM};
        logic [31:0] as[4]  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs[4]  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exps[4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], 2'(i), lat, res, slot);
            n_tests++; if (lat !== 1)       begin n_fail++; $display("FAIL special_lat[%0d] got=%0d exp=1", i, lat); end
            n_tests++; if (res !== exps[i]) begin n_fail++; $display("FAIL special_res[%0d] got=%h exp=%h", i, res, exps[i]); end
            n_tests++; if (slot !== 2'(i))  begin n_fail++; $display("FAIL special_slot[%0d] got=%0d exp=%0d", i, slot, i); end
        end
    endtask

    task automatic test_back_to_back();
        int k; logic got; logic busy_ok;
        bus.m_AluOp = ALU_DIV; bus.m_s1 = 32'hFFFF_FFF9; bus.m_s2 = 32'd2; bus.m_prio = 2'd3;
        k = 0; got = 1'b0; busy_ok = 1'b1;
        while (!got && k < 100) begin
            tick(); k++;
            if (k == 1) begin bus.m_AluOp = ALU_REM; bus.m_prio = 2'd0; end
            if (!bus.md_busy) busy_ok = 1'b0;
            if (bus.md_done) got = 1'b1;
        end
        n_tests++; if (k !== 34)                        begin n_fail++; $display("FAIL b2b_div_lat got=%0d exp=34", k); end
        n_tests++; if (bus.md_result !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL b2b_div_res got=%h exp=fffffffd", bus.md_result); end
        n_tests++; if (bus.md_slot !== 2'd3)            begin n_fail++; $display("FAIL b2b_div_slot got=%0d exp=3", bus.md_slot); end
        n_tests++; if (busy_ok !== 1'b1)                begin n_fail++; $display("FAIL b2b_busy got=%b exp=1", busy_ok); end
        tick();
        n_tests++; if (bus.md_busy !== 1'b0)            begin n_fail++; $display("FAIL b2b_idle_gap got=%b exp=0", bus.md_busy); end
        k = 0; got = 1'b0;
        while (!got && k < 100) begin
            tick(); k++;
            if (k == 1) bus.m_AluOp = 5'd0;
            if (bus.md_done) got = 1'b1;
        end
        n_tests++; if (k !== 34)                        begin n_fail++; $display("FAIL b2b_rem_lat got=%0d exp=34", k); end
        n_tests++; if (bus.md_result !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL b2b_rem_res got=%h exp=ffffffff", bus.md_result); end
        n_tests++; if (bus.md_slot !== 2'd0)            begin n_fail++; $display("FAIL b2b_rem_slot got=%0d exp=0", bus.md_slot); end
        tick();
    endtask

    task automatic test_flush();
        int lat; logic [31:0] res; logic [1:0] slot; logic seen;
        bus.m_AluOp = ALU_DIVU; bus.m_s1 = 32'd100; bus.m_s2 = 32'd7; bus.m_prio = 2'd1;
        seen = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) bus.m_AluOp = 5'd0;
            if (bus.md_done) seen = 1'b1;
        end
        bus.md_flush = 1'b1;
        tick();
        bus.md_flush = 1'b0;
        n_tests++; if (bus.md_busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got=%b exp=0", bus.md_busy); end
        for (int k = 0; k < 40; k++) begin
            if (bus.md_done) seen = 1'b1;
            tick();
        end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_done got=%b exp=0", seen); end
        run_op(ALU_MUL, 32'd3, 32'd4, 2'd2, lat, res, slot);
        n_tests++; if (res !== 32'd12) begin n_fail++; $display("FAIL flush_mul got=%h exp=c", res); end
        n_tests++; if (lat !== 2)      begin n_fail++; $display("FAIL flush_mul_lat got=%0d exp=2", lat); end

        bus.m_AluOp = ALU_DIVU; bus.m_s1 = 32'd100; bus.m_s2 = 32'd7; bus.m_prio = 2'd1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) bus.m_AluOp = 5'd0;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++; if (bus.md_busy !== 1'b0)    begin n_fail++; $display("FAIL rst_busy got=%b exp=0", bus.md_busy); end
        n_tests++; if (bus.md_done !== 1'b0)    begin n_fail++; $display("FAIL rst_done got=%b exp=0", bus.md_done); end
        n_tests++; if (bus.md_result !== 32'h0) begin n_fail++; $display("FAIL rst_result got=%h exp=0", bus.md_result); end
        n_tests++; if (bus.md_slot !== 2'd0)    begin n_fail++; $display("FAIL rst_slot got=%0d exp=0", bus.md_slot); end
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.md_done) seen = 1'b1;
            tick();
        end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_no_done got=%b exp=0", seen); end
    endtask

    task automatic test_early_out();
        int lat; logic [31:0] res; logic [1:0] slot; int exp_lat;
`ifdef MULDIV_EARLY_OUT_EN
        exp_lat = 1;
`else
        exp_lat = 34;
`endif
        run_op(ALU_DIVU, 32'd3, 32'd10, 2'd1, lat, res, slot);
        n_tests++; if (lat !== exp_lat) begin n_fail++; $display("FAIL early_divu_lat got=%0d exp=%0d", lat, exp_lat); end
        n_tests++; if (res !== 32'h0)   begin n_fail++; $display("FAIL early_divu_res got=%h exp=0", res); end
        run_op(ALU_REM, 32'hFFFF_FFFD, 32'd10, 2'd2, lat, res, slot);
        n_tests++; if (lat !== exp_lat)       begin n_fail++; $display("FAIL early_rem_lat got=%0d exp=%0d", lat, exp_lat); end
        n_tests++; if (res !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL early_rem_res got=%h exp=fffffffd", res); end
    endtask

    task automatic test_random();
        int lat; logic [31:0] res; logic [1:0] slot;
        logic [4:0] op; logic [31:0] a, b; logic [1:0] prio; logic [31:0] exp_v;
        for (int i = 0; i < 60; i++) begin
            op   = ALU_MUL + 5'($urandom_range(0, 7));
            prio = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0:       begin a = $urandom; b = 32'd0; end
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2:       begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(1, 60)); end
                3:       begin a = $urandom; b = 32'($urandom_range(1, 9)) ^ {32{$urandom_range(0, 1) == 1}}; end
                default: begin a = $urandom; b = $urandom; end
            endcase
            exp_q.push_back(ref_model(op, a, b));
            run_op(op, a, b, prio, lat, res, slot);
            exp_v = exp_q.pop_front();
            n_tests++; if (res !== exp_v) begin n_fail++; $display("FAIL rand_res[%0d] op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, res, exp_v); end
            n_tests++; if (lat !== ref_latency(op, a, b)) begin n_fail++; $display("FAIL rand_lat[%0d] op=%0d got=%0d exp=%0d", i, op, lat, ref_latency(op, a, b)); end
            n_tests++; if (slot !== prio) begin n_fail++; $display("FAIL rand_slot[%0d] got=%0d exp=%0d", i, slot, prio); end
        end
    endtask

    initial begin
        bus.m_AluOp  = 5'd0;
        bus.m_s1     = 32'h0;
        bus.m_s2     = 32'h0;
        bus.m_prio   = 2'd0;
        bus.md_flush = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_mul();
        test_div_special();
        test_back_to_back();
        test_flush();
        test_early_out();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
